// File: rtl/data_send.sv
// Send-path packet framer: reads a payload from the data RAM port B and streams
// SYNC0, SYNC1, type, length, payload and an XOR checksum over a valid/ready link.
module data_send #(
    parameter int          AW    = 12,
    parameter logic [7:0]  SYNC0 = 8'h55,
    parameter logic [7:0]  SYNC1 = 8'hAA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs,
    output logic          fd,
    input  logic [3:0]    btype,
    input  logic [AW-1:0] ram_addr_init,
    input  logic [AW-1:0] ram_dlen,
    output logic [AW-1:0] ram_rxa,
    input  logic [7:0]    ram_rxd,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HEAD = 3'd1,
        S_ADDR = 3'd2,
        S_WAIT = 3'd3,
        S_DATA = 3'd4,
        S_SUM  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t        state_q;
    logic [2:0]    hidx_q;
    logic [3:0]    btype_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] dlen_q;
    logic [AW-1:0] rem_q;
    logic [AW-1:0] rxa_q;
    logic [7:0]    csum_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic          fd_q;
    logic          xfer;

    // Header byte by position; the length field is split high nibble / low byte.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx,
                                            input logic [3:0] bt,
                                            input logic [AW-1:0] len);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC0;
            3'd1:    b = SYNC1;
            3'd2:    b = {4'h0, bt};
            3'd3:    b = {4'h0, len[11:8]};
            3'd4:    b = len[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign xfer = tx_valid_q & tx_ready;

    // Packet sequencer: every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hidx_q     <= 3'd0;
            btype_q    <= 4'h0;
            addr_q     <= '0;
            dlen_q     <= '0;
            rem_q      <= '0;
            rxa_q      <= '0;
            csum_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fs) begin
                        btype_q    <= btype;
                        addr_q     <= ram_addr_init;
                        dlen_q     <= ram_dlen;
                        rem_q      <= ram_dlen;
                        csum_q     <= 8'h00;
                        hidx_q     <= 3'd0;
                        tx_data_q  <= SYNC0;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_HEAD;
                    end else begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_HEAD: begin
                    if (xfer) begin
                        if (hidx_q == 3'd4) begin
                            if (dlen_q != '0) begin
                                rxa_q      <= addr_q;
                                tx_valid_q <= 1'b0;
                                state_q    <= S_ADDR;
                            end else begin
                                // Empty payload: checksum stays 0x00 and RAM is left alone.
                                tx_data_q <= csum_q;
                                state_q   <= S_SUM;
                            end
                        end else begin
                            hidx_q    <= hidx_q + 3'd1;
                            tx_data_q <= hdr_byte(hidx_q + 3'd1, btype_q, dlen_q);
                        end
                    end else begin
                        state_q <= S_HEAD;
                    end
                end
                S_ADDR: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    tx_data_q  <= ram_rxd;
                    tx_valid_q <= 1'b1;
                    state_q    <= S_DATA;
                end
                S_DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ tx_data_q;
                        rem_q  <= rem_q - AW'(1);
                        rxa_q  <= rxa_q + AW'(1);
                        if (rem_q == AW'(1)) begin
                            tx_data_q <= csum_q ^ tx_data_q;
                            state_q   <= S_SUM;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_ADDR;
                        end
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_SUM: begin
                    if (xfer) begin
                        tx_valid_q <= 1'b0;
                        fd_q       <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        state_q <= S_SUM;
                    end
                end
                S_DONE: begin
                    if (!fs) begin
                        fd_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        fd_q    <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    fd_q       <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign fd       = fd_q;
    assign ram_rxa  = rxa_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_data_send.sv
// Bench for data_send: random packets against a queue-based reference model,
// with a RAM model on port B and a monitor that scores every transferred byte.
module tb_data_send;

    logic        clk;
    logic        rst;
    logic        fs;
    logic        fd;
    logic [3:0]  btype;
    logic [11:0] ram_addr_init;
    logic [11:0] ram_dlen;
    logic [11:0] ram_rxa;
    logic [7:0]  ram_rxd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    bit bp_mode = 1'b0;

    typedef struct packed {
        logic [7:0]  d;
        logic        pay;
        logic [11:0] adr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [4096];

    data_send dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd), .btype(btype),
        .ram_addr_init(ram_addr_init), .ram_dlen(ram_dlen), .ram_rxa(ram_rxa),
        .ram_rxd(ram_rxd), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data for the sampled address appears next cycle.
    always @(posedge clk) ram_rxd <= mem[ram_rxa];

    // Transmitter readiness: always ready, or ~30% ready under backpressure.
    always @(posedge clk) begin
        #1;
        tx_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference packet: header, payload read at wrapping addresses, XOR of payload.
    task automatic push_expected(input logic [3:0] bt, input logic [11:0] a, input logic [11:0] n);
        logic [7:0]  cs;
        logic [11:0] ad;
        exp_t        e;
        cs = 8'h00;
        e.pay = 1'b0; e.adr = 12'h000;
        e.d = 8'h55;             exp_q.push_back(e);
        e.d = 8'hAA;             exp_q.push_back(e);
        e.d = {4'h0, bt};        exp_q.push_back(e);
        e.d = {4'h0, n[11:8]};   exp_q.push_back(e);
        e.d = n[7:0];            exp_q.push_back(e);
        for (int i = 0; i < int'(n); i++) begin
            ad    = a + 12'(i);
            e.d   = mem[ad];
            e.pay = 1'b1;
            e.adr = ad;
            cs    = cs ^ mem[ad];
            exp_q.push_back(e);
        end
        e.d = cs; e.pay = 1'b0; e.adr = 12'h000;
        exp_q.push_back(e);
    endtask

    // Monitor: scores each transfer and checks that a stalled byte holds still.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("stall_valid", 32'(tx_valid), 32'(1'b1));
                chk("stall_data", 32'(tx_data), 32'(pd));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_byte", 32'(tx_data), 32'(mon_e.d));
                    if (mon_e.pay) chk("payload_addr", 32'(ram_rxa), 32'(mon_e.adr));
                end
            end
            pv <= tx_valid;
            pr <= tx_ready;
            pd <= tx_data;
        end
    end

    // drop_at: cycle after the start edge where fs falls; negative holds fs past done.
    task automatic run_pkt(input logic [3:0] bt, input logic [11:0] a, input logic [11:0] n,
                           input int drop_at, input bit timed);
        int cnt;
        push_expected(bt, a, n);
        btype = bt; ram_addr_init = a; ram_dlen = n; fs = 1'b1;
        @(posedge clk); #1;
        btype = 4'($urandom); ram_addr_init = 12'($urandom); ram_dlen = 12'($urandom);
        cnt = 1;
        if (drop_at == 1) fs = 1'b0;
        while (!fd && cnt < 20000) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == drop_at) fs = 1'b0;
        end
        chk("fd_rise", 32'(fd), 32'(1'b1));
        if (timed) chk("fd_latency", 32'(cnt), 32'(7 + 3 * int'(n)));
        chk("bytes_left_at_done", 32'(exp_q.size()), 32'd0);
        chk("done_valid", 32'(tx_valid), 32'(1'b0));
        if (drop_at < 0) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk("fd_held", 32'(fd), 32'(1'b1));
                chk("no_restart", 32'(tx_valid), 32'(1'b0));
            end
            fs = 1'b0;
        end
        @(posedge clk); #1;
        chk("fd_clear", 32'(fd), 32'(1'b0));
        @(posedge clk); #1;
        chk("idle_valid", 32'(tx_valid), 32'(1'b0));
    endtask

    initial begin
        rst = 1'b1; fs = 1'b0; btype = 4'h0; ram_addr_init = 12'h000; ram_dlen = 12'h000;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'h01; mem[12'h011] = 8'h02; mem[12'h012] = 8'h04; mem[12'h013] = 8'h08;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fd", 32'(fd), 32'd0);
        chk("rst_rxa", 32'(ram_rxa), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_pkt(4'd3, 12'h010, 12'd4, 1, 1'b1);      // basic: 55 AA 03 00 04 01 02 04 08 0F
        run_pkt(4'd1, 12'h123, 12'd0, 1, 1'b1);      // zero length
        run_pkt(4'd5, 12'hFFE, 12'd4, 1, 1'b1);      // address wrap
        bp_mode = 1'b1;
        run_pkt(4'd3, 12'h010, 12'd4, 1, 1'b0);      // backpressure
        bp_mode = 1'b0;
        @(posedge clk); #1;
        run_pkt(4'd3, 12'h010, 12'd4, 2, 1'b1);      // fs dropped in k+2
        run_pkt(4'd7, 12'h200, 12'd3, -1, 1'b1);     // fs held through done

        // Reset in the middle of payload byte 2, then a clean packet.
        push_expected(4'd2, 12'h010, 12'd4);
        btype = 4'd2; ram_addr_init = 12'h010; ram_dlen = 12'd4; fs = 1'b1;
        @(posedge clk); #1;
        fs = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_fd", 32'(fd), 32'd0);
        chk("midrst_rxa", 32'(ram_rxa), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_idle", 32'(tx_valid), 32'd0);
        end
        run_pkt(4'd9, 12'h010, 12'd4, 1, 1'b1);

        bp_mode = 1'b1;
        for (int p = 0; p < 6; p++) begin
            run_pkt(4'($urandom), 12'($urandom), 12'($urandom_range(0, 20)), 1, 1'b0);
        end
        bp_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_send.md
# data_send

Packet reader and framer for the send path. On a start/done handshake from the console it reads `ram_dlen` bytes from the port B side of the shared data RAM, beginning at `ram_addr_init`. The RAM contents were written earlier by the data-assembly writer. The block wraps the payload in a fixed header plus an XOR checksum and presents the stream one byte at a time to the line transmitter over a valid/ready handshake. It sits between the data RAM read port and the com transmit encoder, in the com transmit clock domain.

## Interface
Parameters:
- `AW`, 12, RAM address width and length width.
- `SYNC0`, 8'h55, first header byte.
- `SYNC1`, 8'hAA, second header byte.

Ports:
- `clk`  in  1  transmit-domain clock; every register changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fs`  in  1  start request from the console, a level held until `fd` is seen.
- `fd`  out  1  done flag, held high until `fs` is low.
- `btype`  in  4  packet type, latched at start.
- `ram_addr_init`  in  AW  first payload address, latched at start.
- `ram_dlen`  in  AW  payload length in bytes (0..4095), latched at start.
- `ram_rxa`  out  AW  RAM port B address, registered.
- `ram_rxd`  in  8  RAM port B data, valid one cycle after `ram_rxa` is sampled.
- `tx_data`  out  8  byte to the transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts the byte.

## Operation
- Reset value of every output is 0: `fd`, `ram_rxa`, `tx_data`, `tx_valid`. Reset also clears state to IDLE and zeroes the checksum and counters.
- A reset asserted mid-packet aborts the packet, with no partial checksum.
- A byte transfers on any rising edge where `tx_valid & tx_ready`.
- Once `tx_valid` rises, it and `tx_data` stay stable until that transfer completes.
- IDLE:
  - `fs`=1 latches `btype`, `ram_addr_init` and `ram_dlen`, clears the checksum and moves to HEAD.
  - `fs`=0 keeps the block in IDLE.
- HEAD emits five bytes in order: `SYNC0`, `SYNC1`, {4'h0,`btype`}, {4'h0,`dlen`[11:8]}, `dlen`[7:0].
  - After the fifth transfer, go to ADDR if `dlen`≠0, else go to SUM.
  - `ram_rxa` is loaded with the start address on the edge leaving HEAD.
- ADDR holds `ram_rxa` stable for one cycle (RAM samples the address), then moves to WAIT.
- WAIT: `ram_rxd` is valid. At the end of the cycle:
  - capture `ram_rxd` into `tx_data`;
  - set `tx_valid`;
  - go to DATA.
- DATA holds the byte until it transfers. On transfer:
  - checksum ^= byte;
  - remaining -= 1;
  - `ram_rxa` += 1, modulo 2^AW, so 4095 wraps to 0;
  - go to ADDR if remaining≠0, else go to SUM.
- SUM emits the checksum, the XOR of payload bytes only (0x00 when `dlen`=0). On transfer go to DONE.
- DONE:
  - `fd`=1 and `tx_valid`=0.
  - When `fs` is sampled low, clear `fd` and return to IDLE.
  - If `fs` is already low on entry, `fd` is high for exactly one cycle.
- `fs` falling mid-packet is ignored; the packet completes normally.
- Changes on `btype`, `ram_addr_init` or `ram_dlen` after the start edge have no effect on the packet in flight.
- `tx_valid` is 0 in IDLE, ADDR and DONE.

## Timing
- Start latency: `fs` is sampled high at edge k, so `tx_valid`=1 with `tx_data`=`SYNC0` in cycle k+1.
- With `tx_ready` held at 1:
  - header occupies cycles k+1..k+5;
  - each payload byte takes 3 cycles (ADDR, WAIT, DATA), so payload occupies k+6..k+5+3N;
  - the checksum is in cycle k+6+3N;
  - `fd` rises in cycle k+7+3N.
- Each cycle `tx_ready` is low stretches only the current HEAD, DATA or SUM byte by exactly one cycle.
- `ram_rxa` changes only on the edge leaving HEAD or on a DATA transfer, never during ADDR or WAIT.
- Throughput is 1 payload byte per 3 cycles. The transmitter runs slower, so this rate is sufficient.

## Test plan
- **Basic packet:** reset; RAM[0x010..0x013]=01,02,04,08; `btype`=3; `ram_addr_init`=0x010; `ram_dlen`=4; `tx_ready`=1; pulse `fs`.
  - Stream must be 55 AA 03 00 04 01 02 04 08 0F.
  - `fd` rises 19 cycles after the `fs` sample edge.
- **Zero length:** `ram_dlen`=0, `btype`=1 -> stream is 55 AA 01 00 00 00; RAM is never addressed.
- **Address wrap:** `ram_addr_init`=0xFFE, `ram_dlen`=4 -> `ram_rxa` sequence is FFE, FFF, 000, 001. Payload equals RAM at those addresses.
- **Backpressure:** random `tx_ready` at 30% high on the basic packet.
  - Byte sequence is identical to the basic case.
  - `tx_data` never changes while `tx_valid`=1 and `tx_ready`=0.
  - No byte is duplicated or dropped.
- **Handshake edges:**
  - `fs` dropped in cycle k+2 -> the packet completes and `fd` is high exactly 1 cycle.
  - `fs` held high -> `fd` stays high and no second packet starts until `fs` falls and rises again.
- **Reset mid-packet:** assert `rst` during payload byte 2 -> next cycle all outputs are 0 and state is IDLE. A new `fs` produces a complete, correct packet.
